mem_bus_ctrl: RTL
=================

// Module: mem_bus_ctrl
// PURPOSE
//   Parametrised external-memory bus controller; next generation of the top-level memory interface.
//   Accepts 3-bit operation commands with a valid/ready handshake and runs single or burst
//   read/write cycles with programmable wait states on an external address/data bus.
//   Sits between the command-issuing core logic and the external SRAM-style memory.
// PARAMETERS
//   ADDR_W     20  bus address width
//   DATA_W     8   bus data width
//   WAIT_CYC   2   wait states per access, legal range 0..15
//   BURST_LEN  4   beats per burst operation, legal range 2..16
// PORTS
//   clk          in   1       system clock; all logic on rising edge
//   reset        in   1       synchronous, active-high reset
//   OP           in   3       command: 000 NOP, 001 READ, 010 WRITE, 011 BURST_READ, 100 BURST_WRITE
//   op_valid     in   1       OP/addr_in/wdata valid
//   op_ready     out  1       controller can accept a command
//   addr_in      in   ADDR_W  start address of the command
//   wdata        in   DATA_W  write data (per beat in bursts)
//   wdata_ack    out  1       1-cycle pulse: current wdata sampled; present the next beat next cycle
//   rdata        out  DATA_W  read data returned to the core
//   rdata_valid  out  1       1-cycle pulse per read beat
//   err          out  1       1-cycle pulse: illegal or disabled OP consumed
//   busy         out  1       high whenever the FSM is not in IDLE
//   Direction    out  ADDR_W  external bus address
//   Data_out     out  DATA_W  external bus write data
//   Data_in      in   DATA_W  external bus read data
//   cs_n, oe_n, we_n  out 1 each  external chip select, output enable, write enable; active-low
// BEHAVIOUR
// - Reset: all outputs are registered. Direction=0, Data_out=0, rdata=0.
//   cs_n=oe_n=we_n=1. op_ready=1. rdata_valid=wdata_ack=err=busy=0. FSM=IDLE.
// - Handshake: a command is accepted on an edge with op_valid&&op_ready. op_ready=1 only in IDLE.
//   OP=NOP is accepted with no effect.
// - FSM: IDLE -> SETUP -> WAIT (WAIT_CYC cycles; skipped if 0) -> ACCESS -> (NEXT -> SETUP | IDLE).
//   - SETUP: drives Direction, cs_n=0, Data_out=wdata for writes; wdata_ack pulses here.
//   - ACCESS: one cycle with oe_n=0 (read) or we_n=0 (write).
//     Reads sample Data_in at the end of ACCESS, giving rdata/rdata_valid on the following cycle.
//   - NEXT: Direction+1, modulo 2^ADDR_W (all-ones wraps to 0); beat counter +1.
//     Returns to IDLE after the last beat. cs_n stays 0 between the beats of a burst.
// - Timing: accept at edge T gives SETUP at T+1, ACCESS at T+2+WAIT_CYC,
//   single-read rdata_valid at T+3+WAIT_CYC, and op_ready high again at T+3+WAIT_CYC.
//   Burst beat period is 3+WAIT_CYC cycles.
// - Illegal OP (101..111): consumed, err pulses on the next cycle, no bus activity, stays IDLE.
// - op_valid while busy: not accepted. The upstream holds the command until op_ready.
// - Reset mid-operation has priority over everything. The next edge forces IDLE with the reset values;
//   no partial beat completes and no rdata_valid is issued.
// - Invariant: oe_n and we_n are never 0 simultaneously; neither is ever 0 while cs_n=1.
// CONFIGURATION
// - MEM_BUS_BURST_EN defined: BURST_READ/BURST_WRITE run BURST_LEN beats as described above.
// - MEM_BUS_BURST_EN undefined: the burst counter and NEXT state are not built.
//   OP 011/100 are treated as illegal (err pulse, no bus activity).
// TESTING (WAIT_CYC=2, BURST_LEN=4 unless noted)
// - Reset then idle -> op_ready=1, cs_n=oe_n=we_n=1, Direction=0, busy=0.
// - READ addr 0x1234A, Data_in=0x5C -> oe_n low exactly 1 cycle at T+4; rdata=0x5C, rdata_valid at T+5.
// - WRITE addr 0x00010, wdata 0xA5 -> Direction=0x00010, Data_out=0xA5 from T+1.
//   we_n low 1 cycle at T+4; 1 wdata_ack.
// - BURST_READ addr 0xFFFFE (EN) -> beats at 0xFFFFE, 0xFFFFF, 0x00000, 0x00001; 4 rdata_valid 5 cycles apart.
// - OP=110, and OP=011 with the macro undefined -> err pulse next cycle, no cs_n activity, op_ready stays 1.
// - Reset asserted during the WAIT of a READ -> next edge IDLE, cs_n=1, no rdata_valid; a new READ then completes normally.
// - WAIT_CYC=0 READ -> rdata_valid at T+3.

Source files
------------

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: external SRAM-style bus controller.
// Accepts NOP/READ/WRITE (and BURST_READ/BURST_WRITE when the MEM_BUS_BURST_EN
// macro is defined) through a valid/ready handshake. Each access runs
// SETUP -> WAIT x WAIT_CYC -> ACCESS, and bursts add a NEXT cycle between beats.
// All outputs are registered. Each output register is loaded from the decoded
// next state, so the bus pins change on the same edge as the FSM.
module mem_bus_ctrl #(
    parameter int ADDR_W    = 20,
    parameter int DATA_W    = 8,
    parameter int WAIT_CYC  = 2,
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        OP,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wdata,
    output logic              wdata_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              err,
    output logic              busy,
    output logic [ADDR_W-1:0] Direction,
    output logic [DATA_W-1:0] Data_out,
    input  logic [DATA_W-1:0] Data_in,
    output logic              cs_n,
    output logic              oe_n,
    output logic              we_n
);

    localparam logic [2:0] OP_NOP    = 3'b000;
    localparam logic [2:0] OP_READ   = 3'b001;
    localparam logic [2:0] OP_WRITE  = 3'b010;
    localparam logic [2:0] OP_BREAD  = 3'b011;
    localparam logic [2:0] OP_BWRITE = 3'b100;

    // Last value of the wait counter. It is never reached when WAIT_CYC is 0,
    // because SETUP then goes straight to ACCESS.
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYC - 1);

    // Reject out-of-range configurations when the design is elaborated.
    if (WAIT_CYC < 0 || WAIT_CYC > 15) begin : g_bad_wait
        $error("mem_bus_ctrl: WAIT_CYC must be within 0..15");
    end
    if (BURST_LEN < 2 || BURST_LEN > 16) begin : g_bad_burst
        $error("mem_bus_ctrl: BURST_LEN must be within 2..16");
    end

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_ACCESS = 3'd3
`ifdef MEM_BUS_BURST_EN
        , ST_NEXT = 3'd4
`endif
    } state_t;

    state_t     state_r;
    state_t     state_s;
    logic       cmd_read_r;
    logic [3:0] wait_cnt_r;
    logic       start_s;
    logic       start_rd_s;
    logic       illegal_s;
    logic       rd_sel_s;
    logic       last_beat_s;
    logic       enter_next_s;

`ifdef MEM_BUS_BURST_EN
    localparam logic [3:0] BEAT_LAST = 4'(BURST_LEN - 1);
    logic       cmd_burst_r;
    logic       start_burst_s;
    logic [3:0] beat_cnt_r;
`endif

    // Decode the offered command. Only a command that is accepted in IDLE counts.
    always_comb begin
        start_s    = 1'b0;
        start_rd_s = 1'b0;
        illegal_s  = 1'b0;
`ifdef MEM_BUS_BURST_EN
        start_burst_s = 1'b0;
`endif
        if (state_r == ST_IDLE && op_valid) begin
            case (OP)
                OP_NOP: begin
                    start_s = 1'b0;
                end
                OP_READ: begin
                    start_s    = 1'b1;
                    start_rd_s = 1'b1;
                end
                OP_WRITE: begin
                    start_s = 1'b1;
                end
`ifdef MEM_BUS_BURST_EN
                OP_BREAD: begin
                    start_s       = 1'b1;
                    start_rd_s    = 1'b1;
                    start_burst_s = 1'b1;
                end
                OP_BWRITE: begin
                    start_s       = 1'b1;
                    start_burst_s = 1'b1;
                end
`endif
                default: begin
                    illegal_s = 1'b1;
                end
            endcase
        end else begin
            start_s    = 1'b0;
            start_rd_s = 1'b0;
            illegal_s  = 1'b0;
        end
    end

    // Direction of the transfer that the next state belongs to. While IDLE the
    // command being accepted decides it. Otherwise the stored command decides it.
    always_comb begin
        if (state_r == ST_IDLE) begin
            rd_sel_s = start_rd_s;
        end else begin
            rd_sel_s = cmd_read_r;
        end
    end

    // Single accesses always end after one beat. A burst ends on its final beat.
    always_comb begin
`ifdef MEM_BUS_BURST_EN
        if (cmd_burst_r) begin
            last_beat_s = (beat_cnt_r == BEAT_LAST);
        end else begin
            last_beat_s = 1'b1;
        end
`else
        last_beat_s = 1'b1;
`endif
    end

    // Next-state logic for the access sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_s = ST_SETUP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (WAIT_CYC == 0) begin
                    state_s = ST_ACCESS;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_r == WAIT_LAST) begin
                    state_s = ST_ACCESS;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_ACCESS: begin
`ifdef MEM_BUS_BURST_EN
                if (last_beat_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_NEXT;
                end
`else
                if (last_beat_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_IDLE;
                end
`endif
            end
`ifdef MEM_BUS_BURST_EN
            ST_NEXT: begin
                state_s = ST_SETUP;
            end
`endif
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // A step into NEXT advances the bus address and the beat counter.
    always_comb begin
`ifdef MEM_BUS_BURST_EN
        enter_next_s = (state_s == ST_NEXT);
`else
        enter_next_s = 1'b0;
`endif
    end

    // State register and the registered handshake and bus strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            op_ready    <= 1'b1;
            busy        <= 1'b0;
            cs_n        <= 1'b1;
            oe_n        <= 1'b1;
            we_n        <= 1'b1;
            wdata_ack   <= 1'b0;
            err         <= 1'b0;
            rdata_valid <= 1'b0;
        end else begin
            state_r     <= state_s;
            op_ready    <= (state_s == ST_IDLE);
            busy        <= (state_s != ST_IDLE);
            cs_n        <= (state_s == ST_IDLE);
            oe_n        <= !((state_s == ST_ACCESS) && rd_sel_s);
            we_n        <= !((state_s == ST_ACCESS) && !rd_sel_s);
            wdata_ack   <= (state_s == ST_SETUP) && !rd_sel_s;
            err         <= illegal_s;
            rdata_valid <= (state_r == ST_ACCESS) && cmd_read_r;
        end
    end

    // Address, write-data and read-data registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            Direction <= '0;
            Data_out  <= '0;
            rdata     <= '0;
        end else begin
            if (start_s) begin
                Direction <= addr_in;
            end else if (enter_next_s) begin
                Direction <= Direction + {{(ADDR_W-1){1'b0}}, 1'b1};
            end else begin
                Direction <= Direction;
            end
            if ((state_s == ST_SETUP) && !rd_sel_s) begin
                Data_out <= wdata;
            end else begin
                Data_out <= Data_out;
            end
            if ((state_r == ST_ACCESS) && cmd_read_r) begin
                rdata <= Data_in;
            end else begin
                rdata <= rdata;
            end
        end
    end

    // Command latch and the wait/beat counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_read_r <= 1'b0;
            wait_cnt_r <= 4'd0;
`ifdef MEM_BUS_BURST_EN
            cmd_burst_r <= 1'b0;
            beat_cnt_r  <= 4'd0;
`endif
        end else begin
            if (start_s) begin
                cmd_read_r <= start_rd_s;
            end else begin
                cmd_read_r <= cmd_read_r;
            end
            if (state_r == ST_WAIT) begin
                wait_cnt_r <= wait_cnt_r + 4'd1;
            end else begin
                wait_cnt_r <= 4'd0;
            end
`ifdef MEM_BUS_BURST_EN
            if (start_s) begin
                cmd_burst_r <= start_burst_s;
                beat_cnt_r  <= 4'd0;
            end else if (enter_next_s) begin
                cmd_burst_r <= cmd_burst_r;
                beat_cnt_r  <= beat_cnt_r + 4'd1;
            end else begin
                cmd_burst_r <= cmd_burst_r;
                beat_cnt_r  <= beat_cnt_r;
            end
`endif
        end
    end

endmodule
